// File: rtl/ctrl_dab_param_if.sv
// ctrl_dab_param_if -- request/result bundle for the DAB angle controller.
//
// Signals:
//   trigger              start request, sampled only while the controller is idle
//   vdc1, vdc2, iref     signed primary voltage, secondary voltage, current reference
//   fs                   unsigned switching frequency
//   tau1, tau2, phi      signed registered angles (PI_CODE = 2^(W_OUT-1)-1 means pi)
//   mode                 0 equal voltages, 1 reflected vdc2 higher, 2 reflected vdc2 lower
//   busy, done, fault    computing, one-cycle result strobe, invalid-input flag
//   phi_sat              phi was clamped (only with CTRL_DAB_SAT_FLAG_EN defined)
//
// Modports: master drives the request side, slave is the controller.
interface ctrl_dab_param_if #(
    parameter int W_IN  = 14,
    parameter int W_FS  = 19,
    parameter int W_OUT = 9
);
    logic                    trigger;
    logic signed [W_IN-1:0]  vdc1;
    logic signed [W_IN-1:0]  vdc2;
    logic signed [W_IN-1:0]  iref;
    logic [W_FS-1:0]         fs;
    logic signed [W_OUT-1:0] tau1;
    logic signed [W_OUT-1:0] tau2;
    logic signed [W_OUT-1:0] phi;
    logic [1:0]              mode;
    logic                    busy;
    logic                    done;
    logic                    fault;
`ifdef CTRL_DAB_SAT_FLAG_EN
    logic                    phi_sat;

    modport master (output trigger, vdc1, vdc2, iref, fs,
                    input  tau1, tau2, phi, mode, busy, done, fault, phi_sat);
    modport slave  (input  trigger, vdc1, vdc2, iref, fs,
                    output tau1, tau2, phi, mode, busy, done, fault, phi_sat);
`else
    modport master (output trigger, vdc1, vdc2, iref, fs,
                    input  tau1, tau2, phi, mode, busy, done, fault);
    modport slave  (input  trigger, vdc1, vdc2, iref, fs,
                    output tau1, tau2, phi, mode, busy, done, fault);
`endif
endinterface

// File: rtl/ctrl_dab_param.sv
// ctrl_dab_param -- dual-active-bridge angle controller.
//
// On a trigger it latches the inputs, reflects vdc2 through the turns ratio,
// validates the voltages, then runs one shared restoring divider twice: first
// for the duty angle of the higher-voltage bridge, then for the phase shift.
// All results are published together with a one-cycle done strobe.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      ctrl_dab_param_if.slave (trigger, vdc1, vdc2, iref, fs in;
//            tau1, tau2, phi, mode, busy, done, fault [, phi_sat] out)
//
// Optional feature: define CTRL_DAB_SAT_FLAG_EN to add the phi_sat output.
module ctrl_dab_param #(
    parameter int          W_IN    = 14,
    parameter int          W_FS    = 19,
    parameter int          W_OUT   = 9,
    parameter int unsigned N_RATIO = 22528,
    parameter int unsigned K_PHI   = 1,
    parameter int          K_SHIFT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    ctrl_dab_param_if.slave bus
);

    localparam int DIV_BITS = W_IN + W_FS + 15;     // |num| fits exactly in this width
    localparam int CNT_W    = $clog2(DIV_BITS);
    localparam int Q_FRAC   = 12;                   // N_RATIO is Q4.12
    localparam int P_W      = W_IN + 17;            // vdc2 * N_RATIO, full width
    localparam int V2_W     = W_IN + 5;             // reflected vdc2 after the Q_FRAC shift
    localparam int NUM_W    = W_IN + W_FS + 18;     // iref * fs * K_PHI, full width
    localparam int PI_CODE  = 2**(W_OUT-1) - 1;
    localparam int PHI_MAX  = PI_CODE >> 1;

    localparam logic signed [16:0]       N_EXT     = 17'(N_RATIO);
    localparam logic signed [16:0]       K_EXT     = 17'(K_PHI);
    localparam logic [DIV_BITS-1:0]      PI_D      = DIV_BITS'(PI_CODE);
    localparam logic [DIV_BITS-1:0]      PHI_MAX_D = DIV_BITS'(PHI_MAX);
    localparam logic signed [W_OUT-1:0]  PI_O      = W_OUT'(PI_CODE);
    localparam logic signed [W_OUT-1:0]  PHI_MAX_O = W_OUT'(PHI_MAX);
    localparam logic [CNT_W-1:0]         CNT_LAST  = CNT_W'(DIV_BITS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL     = 3'd1,
        CHK     = 3'd2,
        DIV_TAU = 3'd3,
        DIV_PHI = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                  state_r;
    logic signed [W_IN-1:0]  vdc1_r, vdc2_r, iref_r;
    logic [W_FS-1:0]         fs_r;
    logic signed [V2_W-1:0]  vdc2p_r;
    logic signed [NUM_W-1:0] num_r;
    logic [1:0]              mode_pend_r;
    logic signed [W_OUT-1:0] tau1_pend_r, tau2_pend_r, phi_pend_r;
    logic [DIV_BITS-1:0]     dq_r;          // dividend shifts out the top, quotient in the bottom
    logic [DIV_BITS-1:0]     rem_r;
    logic [DIV_BITS-1:0]     divisor_r;
    logic [CNT_W-1:0]        cnt_r;
    logic signed [W_OUT-1:0] tau1_r, tau2_r, phi_r;
    logic [1:0]              mode_r;
    logic                    busy_r, done_r, fault_r;

    logic signed [P_W-1:0]   prod_s;
    logic signed [NUM_W-1:0] num_prod_s;
    logic signed [V2_W-1:0]  vdc1_x_s, min_s, max_s;
    logic [DIV_BITS-1:0]     min_ext_s, max_ext_s, num_mag_s;
    logic [1:0]              mode_s;
    logic                    bad_in_s;
    logic [DIV_BITS:0]       trial_s;
    logic [DIV_BITS-1:0]     rem_nxt_s, dq_nxt_s, q_sh_s;
    logic                    q_bit_s, sat_s;
    logic signed [W_OUT-1:0] tau_q_s, phi_mag_s, phi_val_s;

    // Full-width products from the latched inputs.
    assign prod_s     = vdc2_r * N_EXT;
    assign num_prod_s = iref_r * $signed({1'b0, fs_r}) * K_EXT;
    assign vdc1_x_s   = vdc1_r;
    assign bad_in_s   = vdc1_r[W_IN-1] || (vdc1_r == '0) || vdc2p_r[V2_W-1] || (vdc2p_r == '0);
    assign min_ext_s  = DIV_BITS'($unsigned(min_s));
    assign max_ext_s  = DIV_BITS'($unsigned(max_s));
    assign num_mag_s  = num_r[NUM_W-1] ? DIV_BITS'(-num_r) : DIV_BITS'(num_r);

    // Voltage ordering: which bridge is higher and the resulting mode.
    always_comb begin
        min_s  = vdc1_x_s;
        max_s  = vdc1_x_s;
        mode_s = 2'd0;
        if (vdc2p_r > vdc1_x_s) begin
            max_s  = vdc2p_r;
            mode_s = 2'd1;
        end else if (vdc2p_r < vdc1_x_s) begin
            min_s  = vdc2p_r;
            mode_s = 2'd2;
        end else begin
            mode_s = 2'd0;
        end
    end

    // One restoring-division step; dq_nxt_s holds the finished quotient on the last step.
    always_comb begin
        trial_s = {rem_r, dq_r[DIV_BITS-1]};
        if (trial_s >= {1'b0, divisor_r}) begin
            rem_nxt_s = DIV_BITS'(trial_s - {1'b0, divisor_r});
            q_bit_s   = 1'b1;
        end else begin
            rem_nxt_s = trial_s[DIV_BITS-1:0];
            q_bit_s   = 1'b0;
        end
        dq_nxt_s = {dq_r[DIV_BITS-2:0], q_bit_s};
    end

    // Result shaping: tau quotient never exceeds PI_CODE; phi is scaled, clamped and signed.
    always_comb begin
        tau_q_s = W_OUT'(dq_nxt_s);
        q_sh_s  = dq_nxt_s >> K_SHIFT;
        sat_s   = (q_sh_s > PHI_MAX_D);
        if (sat_s) begin
            phi_mag_s = PHI_MAX_O;
        end else begin
            phi_mag_s = W_OUT'(q_sh_s);
        end
        if (num_r[NUM_W-1]) begin
            phi_val_s = -phi_mag_s;
        end else begin
            phi_val_s = phi_mag_s;
        end
    end

`ifdef CTRL_DAB_SAT_FLAG_EN
    logic sat_pend_r, phi_sat_r;

    // Saturation flag, staged with phi and published in DONE unless the run faulted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_pend_r <= 1'b0;
            phi_sat_r  <= 1'b0;
        end else begin
            if (state_r == DIV_PHI && cnt_r == CNT_LAST) begin
                sat_pend_r <= sat_s;
            end
            if (state_r == DONE && !fault_r) begin
                phi_sat_r <= sat_pend_r;
            end
        end
    end
    assign bus.phi_sat = phi_sat_r;
`endif

    // Controller FSM with datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            vdc1_r      <= '0;
            vdc2_r      <= '0;
            iref_r      <= '0;
            fs_r        <= '0;
            vdc2p_r     <= '0;
            num_r       <= '0;
            mode_pend_r <= 2'd0;
            tau1_pend_r <= '0;
            tau2_pend_r <= '0;
            phi_pend_r  <= '0;
            dq_r        <= '0;
            rem_r       <= '0;
            divisor_r   <= '0;
            cnt_r       <= '0;
            tau1_r      <= '0;
            tau2_r      <= '0;
            phi_r       <= '0;
            mode_r      <= 2'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.trigger) begin
                        vdc1_r  <= bus.vdc1;
                        vdc2_r  <= bus.vdc2;
                        iref_r  <= bus.iref;
                        fs_r    <= bus.fs;
                        busy_r  <= 1'b1;
                        state_r <= MUL;
                    end
                end
                MUL: begin
                    vdc2p_r <= V2_W'(prod_s >>> Q_FRAC);
                    num_r   <= num_prod_s;
                    state_r <= CHK;
                end
                CHK: begin
                    if (bad_in_s) begin
                        fault_r <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        fault_r     <= 1'b0;
                        mode_pend_r <= mode_s;
                        dq_r        <= PI_D * min_ext_s;
                        divisor_r   <= max_ext_s;
                        rem_r       <= '0;
                        cnt_r       <= '0;
                        state_r     <= DIV_TAU;
                    end
                end
                DIV_TAU: begin
                    dq_r  <= dq_nxt_s;
                    rem_r <= rem_nxt_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        // Quotient goes to the higher-voltage bridge.
                        case (mode_pend_r)
                            2'd1: begin
                                tau1_pend_r <= PI_O;
                                tau2_pend_r <= tau_q_s;
                            end
                            2'd2: begin
                                tau1_pend_r <= tau_q_s;
                                tau2_pend_r <= PI_O;
                            end
                            default: begin
                                tau1_pend_r <= PI_O;
                                tau2_pend_r <= PI_O;
                            end
                        endcase
                        dq_r      <= num_mag_s;
                        divisor_r <= DIV_BITS'($unsigned(vdc1_r));
                        rem_r     <= '0;
                        cnt_r     <= '0;
                        state_r   <= DIV_PHI;
                    end
                end
                DIV_PHI: begin
                    dq_r  <= dq_nxt_s;
                    rem_r <= rem_nxt_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_LAST) begin
                        phi_pend_r <= phi_val_s;
                        state_r    <= DONE;
                    end
                end
                DONE: begin
                    // A faulted run keeps the previous results on the outputs.
                    if (!fault_r) begin
                        tau1_r <= tau1_pend_r;
                        tau2_r <= tau2_pend_r;
                        phi_r  <= phi_pend_r;
                        mode_r <= mode_pend_r;
                    end
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.tau1  = tau1_r;
    assign bus.tau2  = tau2_r;
    assign bus.phi   = phi_r;
    assign bus.mode  = mode_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.fault = fault_r;

endmodule

// File: tb/tb_ctrl_dab_param.sv
// tb_ctrl_dab_param -- self-checking bench for ctrl_dab_param: directed
// vectors with literal expectations plus randomized runs checked against an
// arithmetic reference model of the controller's rules.
module tb_ctrl_dab_param;

    localparam int    W_IN  = 14;
    localparam int    W_FS  = 19;
    localparam int    W_OUT = 9;
    localparam longint N_R  = 22528;
    localparam longint K_P  = 1;
    localparam int    K_SH  = 8;
    localparam longint PI_C = 255;
    localparam longint PHI_M = 127;
    localparam int    LAT_OK    = 99;
    localparam int    LAT_FAULT = 3;
    localparam int    WAIT_MAX  = 200;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   last_lat;

    // Reference model state: the values the outputs should hold.
    longint m_tau1, m_tau2, m_phi, m_mode, m_fault, m_sat;

    ctrl_dab_param_if #(.W_IN(W_IN), .W_FS(W_FS), .W_OUT(W_OUT)) bus ();

    ctrl_dab_param #(
        .W_IN(W_IN), .W_FS(W_FS), .W_OUT(W_OUT),
        .N_RATIO(32'd22528), .K_PHI(32'd1), .K_SHIFT(K_SH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: reflected voltage, validity, duty ratio, phase shift.
    task automatic model_calc(input longint v1, input longint v2, input longint ir,
                              input longint f);
        longint v2p, hi, lo, num, mag, q;
        v2p = (v2 * N_R) >>> 12;
        if (v1 <= 0 || v2p <= 0) begin
            m_fault = 1;
        end else begin
            m_fault = 0;
            hi = (v1 > v2p) ? v1 : v2p;
            lo = (v1 > v2p) ? v2p : v1;
            q  = (PI_C * lo) / hi;
            if (v2p == v1) begin
                m_mode = 0; m_tau1 = PI_C; m_tau2 = PI_C;
            end else if (v2p > v1) begin
                m_mode = 1; m_tau1 = PI_C; m_tau2 = q;
            end else begin
                m_mode = 2; m_tau1 = q; m_tau2 = PI_C;
            end
            num = ir * f * K_P;
            mag = (num < 0) ? -num : num;
            q   = (mag / v1) / (64'sd1 << K_SH);
            m_sat = (q > PHI_M) ? 1 : 0;
            if (q > PHI_M) q = PHI_M;
            m_phi = (num < 0) ? -q : q;
        end
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".tau1"},  bus.tau1,  m_tau1);
        check_val({tag, ".tau2"},  bus.tau2,  m_tau2);
        check_val({tag, ".phi"},   bus.phi,   m_phi);
        check_val({tag, ".mode"},  {62'd0, bus.mode}, m_mode);
        check_val({tag, ".fault"}, {63'd0, bus.fault}, m_fault);
`ifdef CTRL_DAB_SAT_FLAG_EN
        check_val({tag, ".phi_sat"}, {63'd0, bus.phi_sat}, m_sat);
`endif
    endtask

    // One transaction; optionally re-pulses trigger with new inputs while busy.
    task automatic do_run(input string tag, input int v1, input int v2, input int ir,
                          input int f, input bit disturb);
        int n;
        int exp_lat;
        model_calc(v1, v2, ir, f);
        exp_lat   = (m_fault != 0) ? LAT_FAULT : LAT_OK;
        bus.vdc1  = W_IN'(v1);
        bus.vdc2  = W_IN'(v2);
        bus.iref  = W_IN'(ir);
        bus.fs    = W_FS'(f);
        bus.trigger = 1'b1;
        @(posedge clk);
        #1;
        bus.trigger = 1'b0;
        check_val({tag, ".busy"}, {63'd0, bus.busy}, 64'sd1);
        check_val({tag, ".done_low"}, {63'd0, bus.done}, 64'sd0);
        n = 0;
        while (n < WAIT_MAX) begin
            n++;
            @(posedge clk);
            #1;
            if (bus.done) break;
            if (disturb && n == 2) begin
                bus.vdc1    = W_IN'($urandom_range(0, 16383));
                bus.vdc2    = W_IN'($urandom_range(0, 16383));
                bus.iref    = W_IN'($urandom_range(0, 16383));
                bus.fs      = W_FS'($urandom_range(0, 524287));
                bus.trigger = 1'b1;
            end else if (disturb && n == 4) begin
                bus.trigger = 1'b0;
            end
        end
        bus.trigger = 1'b0;
        last_lat = bus.done ? n : WAIT_MAX + 1;
        check_val({tag, ".latency"}, last_lat, exp_lat);
        check_outputs(tag);
    endtask

    // Reset in the middle of a computation: outputs clear at once, no done pulse.
    task automatic abort_run;
        int seen_done;
        bus.vdc1 = W_IN'(1000);
        bus.vdc2 = W_IN'(200);
        bus.iref = W_IN'(300);
        bus.fs   = W_FS'(100000);
        bus.trigger = 1'b1;
        @(posedge clk);
        #1;
        bus.trigger = 1'b0;
        seen_done = 0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done = 1;
        end
        rst_n = 1'b0;
        #1;
        check_val("abort.tau1",  bus.tau1, 64'sd0);
        check_val("abort.tau2",  bus.tau2, 64'sd0);
        check_val("abort.phi",   bus.phi,  64'sd0);
        check_val("abort.mode",  {62'd0, bus.mode},  64'sd0);
        check_val("abort.busy",  {63'd0, bus.busy},  64'sd0);
        check_val("abort.fault", {63'd0, bus.fault}, 64'sd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done = 1;
        end
        check_val("abort.no_done", seen_done, 64'sd0);
        m_tau1 = 0; m_tau2 = 0; m_phi = 0; m_mode = 0; m_fault = 0; m_sat = 0;
    endtask

    initial begin
        int v1, v2, ir, f;
        n_cmp = 0;
        n_err = 0;
        m_tau1 = 0; m_tau2 = 0; m_phi = 0; m_mode = 0; m_fault = 0; m_sat = 0;
        rst_n = 1'b0;
        bus.trigger = 1'b0;
        bus.vdc1 = '0;
        bus.vdc2 = '0;
        bus.iref = '0;
        bus.fs   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset.busy", {63'd0, bus.busy}, 64'sd0);
        check_val("reset.done", {63'd0, bus.done}, 64'sd0);
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reflected vdc2 = 1100 > 1000.
        do_run("v1", 1000, 200, 100, 100000, 1'b0);
        check_val("v1.lit_tau2", bus.tau2, 64'sd231);
        check_val("v1.lit_phi",  bus.phi,  64'sd39);
        check_val("v1.lit_lat",  last_lat, 64'sd99);
        // Back-to-back in the idle cycle right after done.
        do_run("v2", 1000, 100, -100, 100000, 1'b0);
        check_val("v2.lit_tau1", bus.tau1, 64'sd140);
        check_val("v2.lit_phi",  bus.phi,  -64'sd39);
        check_val("v2.lit_mode", {62'd0, bus.mode}, 64'sd2);
        do_run("sat_p", 1000, 200, 8000, 100000, 1'b0);
        check_val("sat_p.lit_phi", bus.phi, 64'sd127);
        do_run("sat_n", 1000, 200, -8000, 100000, 1'b0);
        check_val("sat_n.lit_phi", bus.phi, -64'sd127);
        // Invalid voltage: fault, outputs keep the saturated result.
        do_run("fault", 0, 200, 100, 100000, 1'b0);
        check_val("fault.lit_lat", last_lat, 64'sd3);
        check_val("fault.lit_phi", bus.phi, -64'sd127);
        do_run("equal", 1100, 200, 100, 100000, 1'b0);
        check_val("equal.lit_tau1", bus.tau1, 64'sd255);
        check_val("equal.lit_mode", {62'd0, bus.mode}, 64'sd0);
        // Trigger re-pulse and input change while busy.
        do_run("disturb", 1000, 200, 100, 100000, 1'b1);
        abort_run();
        do_run("fresh", 1000, 100, -100, 100000, 1'b0);

        for (int k = 0; k < 24; k++) begin
            v1 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 16383)) - 8192
                                             : int'($urandom_range(1, 8191));
            v2 = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 16383)) - 8192
                                             : int'($urandom_range(1, 8191));
            ir = int'($urandom_range(0, 16383)) - 8192;
            f  = int'($urandom_range(0, 524287));
            do_run("rand", v1, v2, ir, f, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
